// File: rtl/tmo_arb_pkg.sv
// tmo_arb_pkg: shared state encodings, error-counter width and round-robin pick for tmo_arb_ctrl
package tmo_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE_S = 2'b10} arb_state_e;
    localparam int ERR_W = 8;
    // First set request at or above ptr, wrapping modulo n (n <= 8)
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && req[3'(idx)]) rr_pick = 3'(idx);
        end
    endfunction
endpackage

// File: rtl/tmo_arb_ctrl_cbsce3q.sv
// cbsce3q: sync-reset counter with clear and enable, optionally triplicated and voted
module cbsce3q
    import tmo_arb_pkg::*;
#(
    parameter int Width = 8,
    parameter int TMR   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             CE,
    output logic [Width-1:0] Q
);
    logic [Width-1:0] qn;
    always_comb qn = CLR ? '0 : CE ? Q + Width'(1) : Q;
    if (TMR != 0) begin : g_tmr
        logic [Width-1:0] c0, c1, c2;
        always_ff @(posedge CLK) begin
            c0 <= RST ? '0 : qn;
            c1 <= RST ? '0 : qn;
            c2 <= RST ? '0 : qn;
        end
        vote #(.W(Width)) u_vote (.a(c0), .b(c1), .c(c2), .y(Q));
    end else begin : g_one
        logic [Width-1:0] c0;
        always_ff @(posedge CLK) c0 <= RST ? '0 : qn;
        assign Q = c0;
    end
endmodule

// File: rtl/vote.sv
// vote: bitwise two-of-three majority voter
module vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/tmo_arb_ctrl.sv
// tmo_arb_ctrl: round-robin arbiter and timeout sequencer for a shared window counter
// Optional saturating timeout counter on TMO_ERRS when TMO_ARB_ERRCNT_EN is defined.
module tmo_arb_ctrl
    import tmo_arb_pkg::*;
#(
    parameter int Width = 8,
    parameter int NREQ  = 4,
    parameter int TMR   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]  REQ,
    input  logic [Width-1:0] LEN,
    input  logic             ABORT,
    output logic [NREQ-1:0]  GNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             TMO,
    output logic [Width-1:0] CNT,
    output logic [ERR_W-1:0] TMO_ERRS
);
    typedef struct packed {
        arb_state_e       st;
        logic [2:0]       win;
        logic [2:0]       ptr;
        logic [Width-1:0] lim;
        logic             tmo;
`ifdef TMO_ARB_ERRCNT_EN
        logic [ERR_W-1:0] errs;
`endif
    } regs_t;

    regs_t rv, rn;
    logic clr, ce, held, expire;
    logic [2:0] adv;
    logic [NREQ-1:0] gnt_v;
    logic [Width-1:0] cnt;

    assign gnt_v = NREQ'(1) << rv.win;

    always_comb begin
        held   = |(REQ & gnt_v);
        expire = cnt == rv.lim - Width'(1);
        adv    = (rv.win == 3'(NREQ - 1)) ? 3'd0 : rv.win + 3'd1;
        rn     = rv;
        clr    = 1'b0;
        ce     = 1'b0;
        case (rv.st)
            RUN: begin
                if (ABORT) begin
                    rn.st  = IDLE;
                    rn.ptr = adv;
                    clr    = 1'b1;
                end else begin
                    rn.st  = (expire || !held) ? DONE_S : RUN;
                    rn.tmo = expire;
                    ce     = !expire;
                end
            end
            DONE_S: begin
                rn.st  = IDLE;
                rn.ptr = adv;
                clr    = ABORT;
`ifdef TMO_ARB_ERRCNT_EN
                rn.errs = (rv.tmo && rv.errs != '1) ? rv.errs + ERR_W'(1) : rv.errs;
`endif
            end
            default: begin
                rn.st = IDLE;
                if (|REQ) begin
                    rn.st  = RUN;
                    rn.win = rr_pick(8'(REQ), rv.ptr, NREQ);
                    rn.lim = (LEN == '0) ? Width'(1) : LEN;
                    rn.tmo = 1'b0;
                    clr    = 1'b1;
                end
            end
        endcase
    end

    // Every copy loads the voted next value, so a single upset heals at the next edge
    if (TMR != 0) begin : g_tmr
        regs_t r0, r1, r2;
        always_ff @(posedge CLK) begin
            r0 <= RST ? '0 : rn;
            r1 <= RST ? '0 : rn;
            r2 <= RST ? '0 : rn;
        end
        vote #(.W($bits(regs_t))) u_vote (.a(r0), .b(r1), .c(r2), .y(rv));
    end else begin : g_one
        regs_t r0;
        always_ff @(posedge CLK) r0 <= RST ? '0 : rn;
        assign rv = r0;
    end

    cbsce3q #(.Width(Width), .TMR(TMR)) u_cnt (
        .CLK(CLK),
        .RST(RST),
        .CLR(clr),
        .CE (ce),
        .Q  (cnt)
    );

    assign GNT  = (rv.st == RUN) ? gnt_v : '0;
    assign BUSY = rv.st == RUN || rv.st == DONE_S;
    assign DONE = rv.st == DONE_S;
    assign TMO  = rv.tmo;
    assign CNT  = cnt;
`ifdef TMO_ARB_ERRCNT_EN
    assign TMO_ERRS = rv.errs;
`else
    assign TMO_ERRS = '0;
`endif
endmodule
